// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported, variable-latency memory between the
//            instruction-fetch stage and the data-memory stage. One requester
//            is granted at a time. The granted address, write data and write
//            enable are registered onto the memory port and held until the
//            memory signals ready. Read data then comes back with a one-cycle
//            done pulse. Stall outputs freeze the pipeline while an access is
//            outstanding.
//
// Parameters:
//   AW         - address width in bits
//   DW         - data width in bits
//   MAX_STARVE - consecutive data grants allowed while a fetch waits before
//                the fetch is forced through (legal range 1..15)
//
// Ports:
//   clk, rst          - clock (rising edge), synchronous active-low reset
//   if_req/if_addr    - fetch request (level, held until if_done) and address
//   if_rdata/if_done  - fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata - data request (load/store), held until d_done
//   d_rdata/d_done    - load data and its one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata - registered memory request port
//   mem_rdata/mem_ready - memory read data and completion handshake
//   stall_if/stall_mem  - freeze PC + IF/ID, freeze whole pipeline
//
// Optional feature (macro MEM_ARB_PERF_EN):
//   perf_conflicts - saturating count of IDLE cycles with both requesters
//                    eligible
//   perf_wait      - saturating count of cycles with mem_req=1, mem_ready=0
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  // instruction-fetch requester
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  // data-memory requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  // shared memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  // pipeline controller
  output logic          stall_if,
  output logic          stall_mem
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_conflicts,
  output logic [15:0]   perf_wait
`endif
);

  // Starvation counter is 4 bits wide, enough for the 1..15 legal range.
  localparam logic [3:0] c_max_starve = 4'(MAX_STARVE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  state_t        state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic          if_done_q;
  logic [DW-1:0] d_rdata_q;
  logic          d_done_q;
  logic [3:0]    starve_q;
  logic [3:0]    starve_d;

  logic w_idle;
  logic w_if_elig;
  logic w_d_elig;
  logic w_force_fetch;
  logic w_grant_fetch;
  logic w_grant_data;

  // --------------------------------------------------------------------------
  // Grant decode
  // --------------------------------------------------------------------------
  // A requester whose done pulse is high this cycle has just been served; a
  // request it keeps asserted is a new one and only competes from next cycle.
  assign w_idle    = (state_q == ST_IDLE);
  assign w_if_elig = if_req & ~if_done_q;
  assign w_d_elig  = d_req  & ~d_done_q;

  // Data normally wins a tie; once it has won MAX_STARVE times in a row with a
  // fetch pending, the fetch is pushed through. >= keeps the FSM safe should
  // the counter ever hold a value above the limit.
  assign w_force_fetch = w_if_elig & w_d_elig & (starve_q >= c_max_starve);
  assign w_grant_fetch = w_idle & w_if_elig & (~w_d_elig | w_force_fetch);
  assign w_grant_data  = w_idle & w_d_elig  & ~w_force_fetch;

  // --------------------------------------------------------------------------
  // Starvation counter next value
  // --------------------------------------------------------------------------
  // Counts data grants issued while the fetch side is requesting. Any fetch
  // grant, or a data grant with no fetch request present, starts a new run.
  always_comb begin
    starve_d = starve_q;
    if (w_grant_fetch) begin
      starve_d = 4'd0;
    end else if (w_grant_data) begin
      if (!if_req) begin
        starve_d = 4'd0;
      end else if (starve_q < c_max_starve) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration FSM with registered memory-port and completion outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      // An access in flight is simply abandoned; mem_req drops on this edge.
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      starve_q    <= 4'd0;
    end else begin
      // Done signals are single-cycle pulses unless re-set below.
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      starve_q  <= starve_d;

      case (state_q)
        ST_IDLE: begin
          if (w_grant_data) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            state_q     <= ST_DATA;
          end else if (w_grant_fetch) begin
            // Fetches never write; mem_wdata keeps its last value.
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr;
            state_q    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          // mem_req is always high in this state, so mem_ready is only ever
          // looked at while a request is outstanding.
          if (mem_ready) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            if_rdata_q <= mem_rdata;
            if_done_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end

        ST_DATA: begin
          // Stores capture mem_rdata too; the value is meaningless for them.
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            d_rdata_q <= mem_rdata;
            d_done_q  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        default: begin
          // Unused encoding: recover to a quiet idle port.
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;

  // Stall drops in the done cycle so the stage can advance on that edge.
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = d_req  & ~d_done_q;

`ifdef MEM_ARB_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters (saturating)
  // --------------------------------------------------------------------------
  logic [15:0] perf_conflicts_q;
  logic [15:0] perf_conflicts_d;
  logic [15:0] perf_wait_q;
  logic [15:0] perf_wait_d;

  always_comb begin
    perf_conflicts_d = perf_conflicts_q;
    perf_wait_d      = perf_wait_q;
    if (w_idle && w_if_elig && w_d_elig && (perf_conflicts_q != 16'hFFFF)) begin
      perf_conflicts_d = perf_conflicts_q + 16'd1;
    end
    if (mem_req_q && !mem_ready && (perf_wait_q != 16'hFFFF)) begin
      perf_wait_d = perf_wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_conflicts_q <= 16'd0;
      perf_wait_q      <= 16'd0;
    end else begin
      perf_conflicts_q <= perf_conflicts_d;
      perf_wait_q      <= perf_wait_d;
    end
  end

  assign perf_conflicts = perf_conflicts_q;
  assign perf_wait      = perf_wait_q;
`endif

endmodule
`default_nettype wire
